// File: rtl/pool_pkg.sv
// Shared constants and helpers for the global pooling unit.
// Latency: n/a (compile-time functions and types only).
// Backpressure: n/a.
package pool_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } pool_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input longint v);
    int     r;
    longint x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  // Accumulator width: holds N samples of DATA_W bits without overflow.
  function automatic int acc_w(input int data_w, input int n);
    return data_w + clog2(n);
  endfunction

  // Shift of the reciprocal multiply; wide enough for exact division.
  function automatic int shift_w(input int acc_width, input int n);
    return acc_width + clog2(n);
  endfunction

  // Reciprocal multiplier M = ceil(2^S / N).
  function automatic longint recip_m(input int s, input int n);
    return ((longint'(1) << s) + longint'(n) - 1) / longint'(n);
  endfunction

endpackage

// File: rtl/pool_recip_div.sv
// Exact divide of an accumulated sum by the constant N (multiply by M, shift by S).
// Latency: combinational.
// Backpressure: n/a.
// Ports: acc (sum to divide), quot ((acc + bias) / N, floor or round-half-up).
module pool_recip_div
  import pool_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int N     = 196,
  parameter int ROUND = 0
) (
  input  logic [ACC_W-1:0] acc,
  output logic [ACC_W:0]   quot
);

  localparam int     S   = shift_w(ACC_W, N);
  localparam longint M   = recip_m(S, N);
  // M < 2^(S - clog2(N) + 1); one extra bit of headroom.
  localparam int     M_W = S - clog2(N) + 2;
  localparam int     P_W = ACC_W + 1 + M_W;
  localparam logic [ACC_W:0] BIAS = (ROUND != 0) ? (ACC_W+1)'(N / 2) : '0;

  logic [ACC_W:0] biased;
  logic [P_W-1:0] prod;

  // Bias is added at ACC_W+1 bits so a full-scale sum cannot wrap.
  assign biased = {1'b0, acc} + BIAS;
  assign prod   = P_W'(biased) * P_W'(M);
  assign quot   = (ACC_W+1)'(prod >> S);

endmodule

// File: rtl/global_pool_unit_mc.sv
// Multi-channel global average/max pooling over an IMG_W x IMG_H channel-interleaved frame.
// Latency: channel 0 result valid the cycle after the frame's final input beat; then one result per cycle.
// Backpressure: in_ready low while draining; outputs hold while out_valid & !out_ready.
// Ports: clk/rst (async active-high), mode (0 avg, 1 max, latched on first beat),
//        in_data/in_valid/in_ready (input stream), out_data/out_ch/out_last/out_valid/out_ready (results).
module global_pool_unit_mc
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 14,
  parameter int IMG_H  = 14,
  parameter int CH     = 4,
  parameter int ROUND  = 0,
  localparam int CH_W  = (CH > 1) ? clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int N     = IMG_W * IMG_H;
  localparam int ACC_W = acc_w(DATA_W, N);
  localparam int PIX_W = (N > 1) ? clog2(N) : 1;

  pool_state_e       state_q, state_d;
  logic [ACC_W-1:0]  acc_q [CH];
  logic [CH_W-1:0]   ch_cnt_q;
  logic [PIX_W-1:0]  pix_cnt_q;
  pool_mode_e        mode_q;

  logic              in_fire, out_fire, first_beat, last_beat, load_out;
  pool_mode_e        cur_mode;
  logic [ACC_W-1:0]  wr_val, rd_val;
  logic [CH_W-1:0]   rd_idx;
  logic [ACC_W:0]    quot;
  logic [DATA_W-1:0] res;

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign first_beat = (pix_cnt_q == '0) && (ch_cnt_q == '0);
  assign last_beat  = (pix_cnt_q == PIX_W'(N - 1)) && (ch_cnt_q == CH_W'(CH - 1));
  // The first beat of a frame uses the live mode input; it is latched on that same beat.
  assign cur_mode   = (state_q == ST_ACCUM && first_beat) ? pool_mode_e'(mode) : mode_q;

  // Accumulator update value; pixel 0 always loads so stale frames never leak in.
  always_comb begin
    wr_val = ACC_W'(in_data);
    if (pix_cnt_q != '0) begin
      if (cur_mode == POOL_AVG) begin
        wr_val = acc_q[ch_cnt_q] + ACC_W'(in_data);
      end else if (ACC_W'(in_data) <= acc_q[ch_cnt_q]) begin
        wr_val = acc_q[ch_cnt_q];
      end
    end
  end

  // Drain read port: channel 0 at frame end, otherwise the channel after the one on the output.
  // Bypass covers CH == 1, where the final beat writes the channel being read.
  assign rd_idx = (state_q == ST_DRAIN) ? out_ch + CH_W'(1) : '0;
  assign rd_val = (in_fire && ch_cnt_q == rd_idx) ? wr_val : acc_q[rd_idx];

  pool_recip_div #(
    .ACC_W (ACC_W),
    .N     (N),
    .ROUND (ROUND)
  ) u_div (
    .acc  (rd_val),
    .quot (quot)
  );

  assign res      = (cur_mode == POOL_MAX) ? DATA_W'(rd_val) : DATA_W'(quot);
  assign load_out = (in_fire && last_beat) || (out_fire && !out_last);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (in_fire && last_beat) state_d = ST_DRAIN;
      ST_DRAIN: if (out_fire && out_last) state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      in_ready  <= 1'b0;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
      mode_q    <= POOL_AVG;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q  <= state_d;
      // Registered ready: low through reset, high from the first edge in ACCUM.
      in_ready <= (state_d == ST_ACCUM);
      if (in_fire) begin
        if (first_beat) mode_q <= pool_mode_e'(mode);
        if (ch_cnt_q == CH_W'(CH - 1)) begin
          ch_cnt_q  <= '0;
          pix_cnt_q <= last_beat ? '0 : pix_cnt_q + PIX_W'(1);
        end else begin
          ch_cnt_q <= ch_cnt_q + CH_W'(1);
        end
      end
      if (load_out) begin
        out_valid <= 1'b1;
        out_ch    <= rd_idx;
        out_data  <= res;
        out_last  <= (rd_idx == CH_W'(CH - 1));
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (in_fire && ch_cnt_q == CH_W'(i)) acc_q[i] <= wr_val;
      end
    end
  end

endmodule

// File: tb/tb_global_pool_unit_mc.sv
// Randomized bench for global_pool_unit_mc: floor and round-half-up instances share one stimulus stream.
module tb_global_pool_unit_mc;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 14;
  localparam int IMG_H  = 14;
  localparam int CH     = 4;
  localparam int N      = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
  logic [7:0]  out_data0, out_data1;
  logic [1:0]  out_ch0, out_ch1;

  int n_cmp = 0;
  int n_bad = 0;
  int frame [N*CH];
  int w;

  always #5 clk = ~clk;

  global_pool_unit_mc #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .out_data(out_data0), .out_ch(out_ch0), .out_last(out_last0), .out_valid(out_valid0), .out_ready(out_ready));

  global_pool_unit_mc #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .ROUND(1)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_data(out_data1), .out_ch(out_ch1), .out_last(out_last1), .out_valid(out_valid1), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain sum / max over the frame held in 'frame'.
  function automatic int ref_pool(input int c, input bit md, input bit rnd);
    longint sum = 0;
    int     mx  = 0;
    for (int p = 0; p < N; p++) begin
      sum += frame[p*CH + c];
      if (frame[p*CH + c] > mx) mx = frame[p*CH + c];
    end
    if (md) return mx;
    return rnd ? int'((sum + N/2) / N) : int'(sum / N);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit md, input int gap_pct, input int toggle_px,
                            input int stop_px, output int first_wait);
    int wt;
    mode = md;
    first_wait = 0;
    for (int b = 0; b < N*CH; b++) begin
      if (b / CH >= stop_px) begin
        in_valid = 1'b0;
        return;
      end
      if (b / CH == toggle_px && b % CH == 0) mode = ~mode;
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = 8'(frame[b]);
      wt = 0;
      while (!in_ready0 && wt < 50) begin
        tick();
        wt++;
      end
      if (wt >= 50) chk("in_ready wait timeout", 0, 1);
      if (b == 0) first_wait = wt;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input bit md, input int stall);
    int e0 [CH];
    int e1 [CH];
    for (int c = 0; c < CH; c++) begin
      e0[c] = ref_pool(c, md, 1'b0);
      e1[c] = ref_pool(c, md, 1'b1);
    end
    chk("latency out_valid", out_valid0, 1);
    chk("latency out_ch", out_ch0, 0);
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        tick();
        chk("stall out_valid", out_valid0, 1);
        chk("stall out_data", out_data0, e0[0]);
        chk("stall out_ch", out_ch0, 0);
        chk("stall out_last", out_last0, 0);
        chk("stall in_ready", in_ready0, 0);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < CH; c++) begin
      chk("drain out_valid", out_valid0, 1);
      chk("drain out_ch", out_ch0, c);
      chk("drain out_last", out_last0, (c == CH-1));
      chk("drain data floor", out_data0, e0[c]);
      chk("drain data round", out_data1, e1[c]);
      chk("drain round out_ch", out_ch1, c);
      chk("drain round out_valid", out_valid1, 1);
      chk("drain in_ready", in_ready0, 0);
      tick();
    end
    chk("post-drain out_valid", out_valid0, 0);
    chk("post-drain in_ready", in_ready0, 1);
    chk("post-drain in_ready round", in_ready1, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready0, 0);
    chk("reset out_valid", out_valid0, 0);
    chk("reset out_data", out_data0, 0);
    chk("reset out_ch", out_ch0, 0);
    chk("reset out_last", out_last0, 0);
    rst = 1'b0;
    tick();
    chk("in_ready after reset", in_ready0, 1);

    // Full-scale average: exact divider must give 255, not 254.
    for (int i = 0; i < N*CH; i++) frame[i] = 255;
    send_frame(1'b0, 0, -1, N, w);
    collect(1'b0, 5);
    chk("full-scale avg", out_data0, 255);

    // ch0: single 98, ch1: total 97, ch2: pixel index, ch3: random.
    for (int p = 0; p < N; p++) begin
      frame[p*CH + 0] = (p == 7)  ? 98 : 0;
      frame[p*CH + 1] = (p == 11) ? 97 : 0;
      frame[p*CH + 2] = p;
      frame[p*CH + 3] = int'($urandom_range(255));
    end
    send_frame(1'b0, 30, -1, N, w);
    collect(1'b0, 0);
    send_frame(1'b1, 20, -1, N, w);
    collect(1'b1, 2);

    // Back-to-back frames with mode flipped at pixel 50.
    for (int i = 0; i < N*CH; i++) frame[i] = int'($urandom_range(255));
    send_frame(1'b1, 0, 50, N, w);
    collect(1'b1, 0);
    for (int i = 0; i < N*CH; i++) frame[i] = int'($urandom_range(255));
    send_frame(1'b0, 0, 50, N, w);
    chk("back-to-back first beat wait", w, 0);
    collect(1'b0, 0);

    // Reset in the middle of a gappy frame.
    for (int i = 0; i < N*CH; i++) frame[i] = int'($urandom_range(1, 255));
    send_frame(1'b1, 25, -1, 100, w);
    #2;
    rst = 1'b1;
    #1;
    chk("mid-frame reset out_valid", out_valid0, 0);
    chk("mid-frame reset out_data", out_data0, 0);
    chk("mid-frame reset out_ch", out_ch0, 0);
    chk("mid-frame reset out_last", out_last0, 0);
    chk("mid-frame reset in_ready", in_ready0, 0);
    chk("mid-frame reset round out_data", out_data1, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("in_ready after second reset", in_ready0, 1);

    for (int i = 0; i < N*CH; i++) frame[i] = 17;
    send_frame(1'b0, 15, -1, N, w);
    collect(1'b0, 0);
    chk("constant 17 round", out_data1, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/global_pool_unit_mc.md
# global_pool_unit_mc

Multi-channel global pooling unit: the parametrised successor to the single-channel 14x14 average pooler. It consumes a channel-interleaved feature-map stream (IMG_W*IMG_H pixels, CH values per pixel) under valid/ready flow control. It accumulates per-channel sums or maxima and emits one CH-long result vector per frame with backpressure support. It sits between the last conv/activation stage and the classifier FC layer.

## Interface

Parameters:
- DATA_W, 8: unsigned input/output sample width.
- IMG_W, 14: frame width in pixels.
- IMG_H, 14: frame height in pixels.
- CH, 4: channels per pixel (interleaved, channel 0 first).
- ROUND, 0: 0 = floor average; 1 = round-half-up average.

Ports:
- Reset is asynchronous and active-high.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- mode  in  1  0 = average, 1 = max. Sampled on the first accepted beat of a frame.
- in_data  in  DATA_W  sample for the current channel.
- in_valid  in  1  in_data valid.
- in_ready  out  1  unit accepts a beat. A beat transfers on in_valid & in_ready.
- out_data  out  DATA_W  pooled result.
- out_ch  out  clog2(CH) (min 1)  channel index of out_data.
- out_last  out  1  high with the channel CH-1 result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts. A result transfers on out_valid & out_ready.

## Operation

- Derived constants: N = IMG_W*IMG_H; ACC_W = DATA_W + clog2(N); S = ACC_W + clog2(N); M = ceil(2^S / N).
- State ACCUM:
  - in_ready = 1.
  - On each transfer, beat k of pixel p updates acc[ch_cnt], where ch_cnt = k.
  - avg mode: acc += in_data. Pixel 0 loads in_data rather than adding to a stale value.
  - max mode: acc = max(acc, in_data). Pixel 0 loads in_data.
  - ch_cnt wraps at CH-1 and then increments pix_cnt.
- Frame end: the transfer with pix_cnt = N-1 and ch_cnt = CH-1 moves the unit to DRAIN.
- State DRAIN:
  - in_ready = 0.
  - Results are emitted for channels 0..CH-1 in order.
  - avg result = ((acc + (ROUND ? N/2 : 0)) * M) >> S, computed at ACC_W+1 bits. This is exact floor/round division and never exceeds 2^DATA_W-1.
  - max result = acc.
  - After the CH-1 result transfers, return to ACCUM with counters at 0.
- mode is latched per frame. Changes mid-frame or mid-drain have no effect until the next frame's first beat.
- in_valid gaps are allowed at any beat. Counters advance only on transfers.

## Timing

- Reset values: in_ready = 0 while rst is asserted and 1 from the first clk edge after release. out_valid = 0, out_data = 0, out_ch = 0, out_last = 0. State = ACCUM, counters = 0, mode latch = 0.
- Latency: the final input transfer at edge t gives out_valid = 1 with channel 0 after edge t.
- With out_ready held at 1, one result transfers per cycle: CH cycles of out_valid, and in_ready = 1 in the cycle after the last output transfer.
- Backpressure: while out_valid & !out_ready, out_data, out_ch and out_last hold stable.
- out_valid never drops without a transfer.
- Rest is asynchronous. Asserted mid-frame or mid-drain, it discards all partial sums and pending outputs.
- Output is registered. There is no combinational path from out_ready to out_valid/out_data, and in_ready depends only on state.

## Structure

- Shared package `pool_pkg`: clog2 function, ACC_W/S/M derivation functions, and a mode enum (POOL_AVG, POOL_MAX).
- Accumulator bank: CH x ACC_W register array, single read/write port indexed by ch_cnt in ACCUM and by drain index in DRAIN.
- One sub-module, `pool_recip_div`: a combinational exact divide-by-constant (multiply, shift, optional rounding bias) with parameters ACC_W, N and ROUND.

## Test plan

- Defaults, avg, all samples 255 → four outputs 255, out_ch 0..3, out_last on ch 3. The exact divider must not yield 254.
- Defaults, avg: ch0 has one pixel = 98 and the rest 0; ch1 = 97 total. ROUND=0 → 0, 0. ROUND=1 → 1, 0.
- Defaults: ch2 sample = pixel index p (0..195). avg ROUND=0 → 97, ROUND=1 → 98; max → 195.
- Backpressure: out_ready = 0 for 5 cycles after the first out_valid → out_data/out_ch stable, in_ready = 0. After release, the 4 results drain in 4 cycles.
- Random in_valid gaps; rst asserted after 100 pixels → all outputs 0 immediately. The next clean frame of constant 17 → four outputs of 17.
- Back-to-back frames with out_ready = 1 and mode toggled at pixel 50 of frame 1 → frame 1 uses the mode latched at its start. Frame 2's first beat is accepted the cycle after frame 1's last output transfer.
